// File: rtl/sobol_rng_param_if.sv
// rtl/sobol_rng_param_if.sv - Control, load and output bundle for the Sobol sequence generator
interface sobol_rng_param_if #(
  parameter int WIDTH    = 8,
  parameter int LOGWIDTH = 3
);
  logic                enable;
  logic                restart;
  logic                load_en;
  logic [LOGWIDTH-1:0] load_idx;
  logic [WIDTH-1:0]    load_vec;
  logic [WIDTH-1:0]    scramble;
  logic [WIDTH-1:0]    value;
  logic [WIDTH-1:0]    seq_out;
  logic                bit_out;
  logic                wrap;

  modport master (
    output enable, restart, load_en, load_idx, load_vec, scramble, value,
    input  seq_out, bit_out, wrap
  );

  modport slave (
    input  enable, restart, load_en, load_idx, load_vec, scramble, value,
    output seq_out, bit_out, wrap
  );
endinterface

// File: rtl/sobol_rng_param.sv
// rtl/sobol_rng_param.sv - Parameterised Sobol low-discrepancy sequence generator with stochastic bit output
module sobol_rng_param #(
  parameter int WIDTH    = 8,
  parameter int LOGWIDTH = 3
) (
  input logic              clk,
  input logic              rst,
  sobol_rng_param_if.slave bus
);
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    seq_q, seq_d;
  logic                wrap_q, wrap_d;
  logic [WIDTH-1:0]    dir_q [WIDTH];
  logic [WIDTH-1:0]    dir_d [WIDTH];
  logic [LOGWIDTH-1:0] step_idx;
  logic                load_ok;
  logic [WIDTH-1:0]    seq_out_w;

  // Indices beyond the vector bank are silently dropped
  assign load_ok = bus.load_en && (int'(bus.load_idx) < WIDTH);

  // Step index is the lowest clear bit of the pre-increment counter
  always_comb begin
    step_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!cnt_q[i]) step_idx = LOGWIDTH'(i);
    end
  end

  // Counter/sequence advance; restart wins over enable, terminal count wraps to zero
  always_comb begin
    cnt_d  = cnt_q;
    seq_d  = seq_q;
    wrap_d = 1'b0;
    if (bus.restart) begin
      cnt_d = '0;
      seq_d = '0;
    end else if (bus.enable) begin
      if (&cnt_q) begin
        cnt_d  = '0;
        seq_d  = '0;
        wrap_d = 1'b1;
      end else begin
        seq_d = seq_q ^ dir_q[step_idx];
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  // Direction-vector writes; a step in the same cycle still sees the old vector
  always_comb begin
    for (int i = 0; i < WIDTH; i++) dir_d[i] = dir_q[i];
    if (load_ok) dir_d[bus.load_idx] = bus.load_vec;
  end

  // State registers; reset restores the van der Corput vectors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      seq_q  <= '0;
      wrap_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) dir_q[i] <= WIDTH'(1) << (WIDTH - 1 - i);
    end else begin
      cnt_q  <= cnt_d;
      seq_q  <= seq_d;
      wrap_q <= wrap_d;
      for (int i = 0; i < WIDTH; i++) dir_q[i] <= dir_d[i];
    end
  end

  assign seq_out_w   = seq_q ^ bus.scramble;
  assign bus.seq_out = seq_out_w;
  assign bus.bit_out = bus.value > seq_out_w;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_sobol_rng_param.sv
// tb/tb_sobol_rng_param.sv - Randomised and directed self-checking bench for sobol_rng_param
module tb_sobol_rng_param;
  localparam int W  = 4;
  localparam int LW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sobol_rng_param_if #(.WIDTH(W), .LOGWIDTH(LW)) bus_if ();

  sobol_rng_param #(.WIDTH(W), .LOGWIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integers
  int m_cnt, m_seq, m_wrap;
  int m_dir [W];

  logic [W-1:0] obs_seq;
  logic         obs_bit;
  logic         obs_wrap;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_seq  = 0;
    m_wrap = 0;
    for (int i = 0; i < W; i++) m_dir[i] = 1 << (W - 1 - i);
  endtask

  task automatic model_edge();
    int k;
    int period_end;
    period_end = (1 << W) - 1;
    if (bus_if.restart) begin
      m_cnt = 0; m_seq = 0; m_wrap = 0;
    end else if (bus_if.enable) begin
      if (m_cnt == period_end) begin
        m_cnt = 0; m_seq = 0; m_wrap = 1;
      end else begin
        k = 0;
        while (((m_cnt >> k) & 1) != 0) k++;
        m_seq  = m_seq ^ m_dir[k];
        m_cnt  = m_cnt + 1;
        m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
    if (bus_if.load_en && int'(bus_if.load_idx) < W) m_dir[bus_if.load_idx] = int'(bus_if.load_vec);
  endtask

  task automatic check_model(string tag);
    int exp_out;
    exp_out = (m_seq ^ int'(bus_if.scramble)) & ((1 << W) - 1);
    check({tag, "_seq"}, 32'(bus_if.seq_out), 32'(exp_out));
    check({tag, "_bit"}, 32'(bus_if.bit_out), 32'(int'(bus_if.value) > exp_out));
    check({tag, "_wrap"}, 32'(bus_if.wrap), 32'(m_wrap));
  endtask

  // One clock: sample at the falling edge, then let DUT and model take the rising edge
  task automatic cycle(string tag);
    @(negedge clk);
    obs_seq  = bus_if.seq_out;
    obs_bit  = bus_if.bit_out;
    obs_wrap = bus_if.wrap;
    check_model(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.enable  = 1'b0;
    bus_if.restart = 1'b0;
    bus_if.load_en = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("arst_seq", 32'(bus_if.seq_out), 32'(bus_if.scramble));
    check("arst_wrap", 32'(bus_if.wrap), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int exp31 [17] = '{0, 8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1, 0};
    int exp32 [5]  = '{0, 8, 8, 8, 12};
    int en32  [5]  = '{1, 0, 0, 1, 0};
    int vals34 [3] = '{8, 0, 15};
    int exp34  [3] = '{8, 0, 15};
    int visited [16];
    int distinct;
    int ones;

    rst             = 1'b1;
    idle_inputs();
    bus_if.load_idx = '0;
    bus_if.load_vec = '0;
    bus_if.scramble = 4'hA;
    bus_if.value    = 4'hB;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seq", 32'(bus_if.seq_out), 32'd10);
    check("rst_bit", 32'(bus_if.bit_out), 32'd1);
    check("rst_wrap", 32'(bus_if.wrap), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Full period with default vectors
    bus_if.scramble = '0;
    bus_if.value    = '0;
    for (int i = 0; i < 16; i++) visited[i] = 0;
    for (int i = 0; i < 17; i++) begin
      bus_if.enable = 1'b1;
      cycle("p31");
      check("seq31_tab", 32'(obs_seq), 32'(exp31[i]));
      check("wrap31", 32'(obs_wrap), 32'(i == 16));
      if (i < 16) visited[obs_seq]++;
    end
    distinct = 0;
    for (int i = 0; i < 16; i++) if (visited[i] == 1) distinct++;
    check("cover26", 32'(distinct), 32'd16);

    // Enable gaps hold state
    idle_inputs();
    bus_if.restart = 1'b1;
    cycle("r32");
    bus_if.restart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_if.enable = 1'(en32[i]);
      cycle("p32");
      check("seq32_tab", 32'(obs_seq), 32'(exp32[i]));
      check("wrap32", 32'(obs_wrap), 32'd0);
    end

    // Load alongside a step uses the old vector
    idle_inputs();
    bus_if.restart = 1'b1;
    cycle("r33");
    idle_inputs();
    bus_if.enable   = 1'b1;
    bus_if.load_en  = 1'b1;
    bus_if.load_idx = 2'd0;
    bus_if.load_vec = 4'd5;
    cycle("p33");
    idle_inputs();
    cycle("p33");
    check("load33_first", 32'(obs_seq), 32'd8);
    bus_if.restart = 1'b1;
    cycle("p33");
    idle_inputs();
    bus_if.enable = 1'b1;
    cycle("p33");
    cycle("p33");
    check("load33_a", 32'(obs_seq), 32'd5);
    bus_if.enable = 1'b0;
    cycle("p33");
    check("load33_b", 32'(obs_seq), 32'd1);

    // Restart beats enable and keeps the vector bank
    bus_if.restart = 1'b1;
    cycle("r35");
    idle_inputs();
    bus_if.enable = 1'b1;
    repeat (5) cycle("p35");
    bus_if.restart = 1'b1;
    cycle("p35");
    idle_inputs();
    cycle("p35");
    check("rs35_seq", 32'(obs_seq), 32'd0);
    check("rs35_wrap", 32'(obs_wrap), 32'd0);
    bus_if.enable = 1'b1;
    cycle("p35");
    bus_if.enable = 1'b0;
    cycle("p35");
    check("rs35_dir", 32'(obs_seq), 32'd5);
    bus_if.enable = 1'b1;
    cycle("p35");
    async_reset();
    idle_inputs();
    bus_if.enable = 1'b1;
    cycle("p35");
    bus_if.enable = 1'b0;
    cycle("p35");
    check("rst35_dir", 32'(obs_seq), 32'd8);

    // Stochastic bit density over one period
    for (int v = 0; v < 3; v++) begin
      bus_if.value   = 4'(vals34[v]);
      idle_inputs();
      bus_if.restart = 1'b1;
      cycle("r34");
      idle_inputs();
      bus_if.enable  = 1'b1;
      ones = 0;
      for (int i = 0; i < 16; i++) begin
        cycle("p34");
        if (obs_bit) ones++;
      end
      check("bits34", 32'(ones), 32'(exp34[v]));
    end

    // Output scrambling
    idle_inputs();
    bus_if.value    = '0;
    bus_if.scramble = 4'hF;
    async_reset();
    bus_if.enable = 1'b1;
    cycle("p36");
    check("scr36_a", 32'(obs_seq), 32'd15);
    bus_if.enable = 1'b0;
    cycle("p36");
    check("scr36_b", 32'(obs_seq), 32'd7);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus_if.enable   = ($urandom_range(0, 3) != 0);
      bus_if.restart  = ($urandom_range(0, 15) == 0);
      bus_if.load_en  = ($urandom_range(0, 7) == 0);
      bus_if.load_idx = LW'($urandom_range(0, W - 1));
      bus_if.load_vec = W'($urandom);
      bus_if.scramble = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      bus_if.value    = W'($urandom);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sobol_rng_param.md
SOBOL_RNG_PARAM -- requirements
Module: sobol_rng_param

Interface
REQ-001 Parameter WIDTH, default 8: sequence, counter and direction-vector width in bits (range 2..16).
REQ-002 Parameter LOGWIDTH, default 3: width of vector index, equal to ceil(log2(WIDTH)).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  advance sequence by one step this cycle.
REQ-006 restart  in  1  synchronous clear of counter and sequence state.
REQ-007 load_en  in  1  write load_vec into direction vector load_idx.
REQ-008 load_idx  in  LOGWIDTH  direction-vector index to write.
REQ-009 load_vec  in  WIDTH  direction-vector value to write.
REQ-010 scramble  in  WIDTH  XOR mask applied to the output sequence.
REQ-011 value  in  WIDTH  unsigned operand for bitstream comparison.
REQ-012 seq_out  out  WIDTH  current scrambled sequence value.
REQ-013 bit_out  out  1  stochastic bit, 1 when value > seq_out (unsigned).
REQ-014 wrap  out  1  one-cycle pulse marking completion of a full 2^WIDTH period.

Function
REQ-015 State: counter cnt[WIDTH], sequence register seq[WIDTH], vector bank dir[0..WIDTH-1] each WIDTH bits, registered wrap.
REQ-016 Step index k = position of the least significant 0 bit of cnt, using the current (pre-increment) cnt.
REQ-017 On enable, restart=0, cnt != all-ones: seq <= seq XOR dir[k]; cnt <= cnt+1; wrap <= 0.
REQ-018 On enable, restart=0, cnt == all-ones: seq <= 0; cnt <= 0; wrap <= 1 for exactly that next cycle.
REQ-019 With enable=0 and restart=0: cnt and seq hold; wrap <= 0.
REQ-020 restart=1 has priority over enable: cnt <= 0, seq <= 0, wrap <= 0; dir bank untouched.
REQ-021 load_en=1 with load_idx < WIDTH: dir[load_idx] <= load_vec at the edge; load_idx >= WIDTH ignored.
REQ-022 Simultaneous load_en and enable: the step uses the pre-load dir value; new value takes effect from the next step.
REQ-023 load_en operates independently of restart; both can act in the same cycle.
REQ-024 seq_out = seq XOR scramble, combinational; no added latency.
REQ-025 bit_out = (value > seq_out), combinational unsigned compare; value = 0 gives bit_out = 0 always.
REQ-026 With default vectors and scramble=0, seq visits every WIDTH-bit value exactly once per 2^WIDTH enabled steps.

Reset
REQ-027 While rst=1: cnt=0, seq=0, wrap=0, dir[i] = 1 << (WIDTH-1-i) (dimension-1 van der Corput vectors).
REQ-028 Outputs after reset: seq_out = scramble, bit_out = (value > scramble), wrap = 0.
REQ-029 rst asserted mid-operation clears state immediately, overrides any load, and discards all programmed vectors.
REQ-030 Following rst deassertion, the first rising edge with enable=1 performs step k=0.

Verification (WIDTH=4, LOGWIDTH=2 unless stated)
REQ-031 Reset, scramble=0, enable=1 for 16 cycles -> seq_out = 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1 then 0; wrap=1 only in the cycle seq_out returns to 0.
REQ-032 enable toggled 1,0,0,1 from reset -> seq_out 0,8,8,8,12; cnt and wrap hold during idle cycles.
REQ-033 load_en=1, load_idx=0, load_vec=5 together with the first enable -> first step gives 8; then restart, steps give 5, 5^4=1.
REQ-034 value=8, scramble=0, 16 enabled cycles -> bit_out=1 in exactly 8 cycles; value=0 -> 0 cycles; value=15 -> 15 cycles.
REQ-035 restart and enable both high after 5 steps -> seq_out=0 next cycle, wrap=0, dir unchanged; rst mid-sequence after a load -> dir[0] back to 8.
REQ-036 scramble=4'hF after reset -> seq_out=15; one enabled step -> seq_out=7.
